// File: rtl/sm4_round_sequencer.sv
// SM4 round / key-schedule sequencer: stalls the pipeline, runs key
// expansion when needed, then ascending or descending data rounds.
//
// Ports:
//   clk, rest           clock, synchronous active-high reset
//   valid_in            cipher instruction present (held while stalled)
//   mode_dec            0 encrypt, 1 decrypt; sampled at start
//   key_change          pulse: round keys become stale
//   hold_pipeline       stall request
//   save_data           one-cycle capture strobe
//   busy                key expansion or data rounds in progress
//   round_idx           round-key index of the current data round
//   rk_we, rk_idx       round-key RAM write enable / address
//   key_ready           round keys valid for the current key
module sm4_round_sequencer #(
  parameter int ROUNDS     = 32,
  parameter int KEY_ROUNDS = 32,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             valid_in,
  input  logic             mode_dec,
  input  logic             key_change,
  output logic             hold_pipeline,
  output logic             save_data,
  output logic             busy,
  output logic [CNT_W-1:0] round_idx,
  output logic             rk_we,
  output logic [CNT_W-1:0] rk_idx,
  output logic             key_ready
);

  localparam int MAX_R = (ROUNDS > KEY_ROUNDS) ? ROUNDS : KEY_ROUNDS;

  generate
    if ((64'd1 << CNT_W) < 64'(MAX_R)) begin : g_bad_cnt_w
      $error("sm4_round_sequencer: CNT_W too narrow for ROUNDS/KEY_ROUNDS");
    end
    if (ROUNDS < 2 || KEY_ROUNDS < 1) begin : g_bad_rounds
      $error("sm4_round_sequencer: ROUNDS >= 2 and KEY_ROUNDS >= 1 required");
    end
  endgenerate

  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(KEY_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYEXP,
    S_ROUND,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             stale_q, stale_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    stale_d = stale_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          mode_d  = mode_dec;
          cnt_d   = '0;
          state_d = (stale_q || key_change) ? S_KEYEXP : S_ROUND;
        end
      end
      S_KEYEXP: begin
        if (!valid_in) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == K_LAST) begin
          state_d = S_ROUND;
          cnt_d   = '0;
          stale_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ROUND: begin
        if (!valid_in) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == R_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // a new key always wins over completion of the expansion
    if (key_change) stale_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      stale_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      stale_q <= stale_d;
    end
  end

  // active-state outputs follow valid_in so a flush drops the stall
  // in the same cycle
  always_comb begin
    hold_pipeline = 1'b0;
    save_data     = 1'b0;
    busy          = 1'b0;
    round_idx     = '0;
    rk_we         = 1'b0;
    rk_idx        = '0;
    unique case (state_q)
      S_IDLE: begin
        hold_pipeline = valid_in;
      end
      S_KEYEXP: begin
        hold_pipeline = valid_in;
        busy          = valid_in;
        rk_we         = valid_in;
        rk_idx        = cnt_q;
      end
      S_ROUND: begin
        hold_pipeline = valid_in;
        busy          = valid_in;
        round_idx     = mode_q ? (R_LAST - cnt_q) : cnt_q;
      end
      S_DONE: begin
        save_data = ~rest;
      end
      default: begin
        hold_pipeline = 1'b0;
      end
    endcase
  end

  assign key_ready = ~stale_q;

endmodule

// File: tb/tb_sm4_round_sequencer.sv
// Bench for sm4_round_sequencer: vector table on a small instance,
// directed sequences and random traffic on the default instance.
module tb_sm4_round_sequencer;

  localparam int R  = 32;
  localparam int KR = 32;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rest, valid_in, mode_dec, key_change;
  logic       hold_pipeline, save_data, busy, rk_we, key_ready;
  logic [4:0] round_idx, rk_idx;

  logic       s_rest, s_valid, s_mode, s_kc;
  logic       s_hold, s_save, s_busy, s_rkwe, s_krdy;
  logic [2:0] s_ridx, s_rkidx;

  sm4_round_sequencer #(.ROUNDS(R), .KEY_ROUNDS(KR), .CNT_W(5)) dut (
    .clk(clk), .rest(rest), .valid_in(valid_in),
    .mode_dec(mode_dec), .key_change(key_change),
    .hold_pipeline(hold_pipeline), .save_data(save_data),
    .busy(busy), .round_idx(round_idx), .rk_we(rk_we),
    .rk_idx(rk_idx), .key_ready(key_ready)
  );

  sm4_round_sequencer #(.ROUNDS(8), .KEY_ROUNDS(4), .CNT_W(3)) dut_s (
    .clk(clk), .rest(s_rest), .valid_in(s_valid),
    .mode_dec(s_mode), .key_change(s_kc),
    .hold_pipeline(s_hold), .save_data(s_save),
    .busy(s_busy), .round_idx(s_ridx), .rk_we(s_rkwe),
    .rk_idx(s_rkidx), .key_ready(s_krdy)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chkx(input string n, input logic [31:0] act, input int exp);
    nvec++;
    if ($isunknown(act) || act != 32'(exp)) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0d", n, act, exp);
    end
  endtask

  // ---------------- reference model: per-instruction schedule ----------
  typedef struct {
    int hold, save, busy, rkwe, rkidx, ridx;
    bit lastk, done;
  } exp_t;

  exp_t sched[$];
  bit   stale_m = 1'b1;

  int o_hold, o_save, o_busy, o_rkwe, o_kr, o_ridx;

  function automatic void plan(bit md);
    exp_t e;
    if (stale_m) begin
      for (int i = 0; i < KR; i++) begin
        e = '{default: 0};
        e.hold = 1; e.busy = 1; e.rkwe = 1; e.rkidx = i;
        e.lastk = (i == KR - 1);
        sched.push_back(e);
      end
    end
    for (int i = 0; i < R; i++) begin
      e = '{default: 0};
      e.hold = 1; e.busy = 1;
      e.ridx = md ? (R - 1 - i) : i;
      sched.push_back(e);
    end
    e = '{default: 0};
    e.save = 1; e.done = 1;
    sched.push_back(e);
  endfunction

  task automatic step(input bit r, input bit v, input bit md, input bit kc);
    exp_t e;
    bit   ck_idx;
    @(posedge clk);
    #1;
    rest = r; valid_in = v; mode_dec = md; key_change = kc;
    #3;
    o_hold = int'(hold_pipeline); o_save = int'(save_data);
    o_busy = int'(busy); o_rkwe = int'(rk_we);
    o_kr = int'(key_ready); o_ridx = int'(round_idx);
    if (r) begin
      sched.delete();
      stale_m = 1'b1;
    end else begin
      e = '{default: 0};
      ck_idx = 1'b1;
      if (sched.size() == 0) begin
        e.hold = int'(v);
      end else if (sched[0].done || v) begin
        e = sched[0];
      end else begin
        ck_idx = 1'b0;
      end
      chkx("hold_pipeline", 32'(hold_pipeline), e.hold);
      chkx("save_data", 32'(save_data), e.save);
      chkx("busy", 32'(busy), e.busy);
      chkx("rk_we", 32'(rk_we), e.rkwe);
      chkx("key_ready", 32'(key_ready), stale_m ? 0 : 1);
      if (ck_idx) begin
        chkx("rk_idx", 32'(rk_idx), e.rkidx);
        chkx("round_idx", 32'(round_idx), e.ridx);
      end
      // advance the model across the clock edge
      if (sched.size() == 0) begin
        if (v) begin
          stale_m = stale_m | kc;
          plan(md);
        end
      end else if (sched[0].done || v) begin
        if (sched[0].lastk && !kc) stale_m = 1'b0;
        void'(sched.pop_front());
      end else begin
        sched.delete();
      end
      if (kc) stale_m = 1'b1;
    end
  endtask

  int kr_a[128], hold_a[128], busy_a[128], ridx_a[128];
  int save_at, nsave, nrkwe;

  task automatic run(input int n, input int vlen, input bit md,
                     input int kc_at, input int flip_at);
    save_at = -1; nsave = 0; nrkwe = 0;
    for (int c = 0; c < n; c++) begin
      step(1'b0, c < vlen, (flip_at >= 0 && c >= flip_at) ? ~md : md,
           c == kc_at);
      kr_a[c] = o_kr; hold_a[c] = o_hold;
      busy_a[c] = o_busy; ridx_a[c] = o_ridx;
      if (o_save != 0) begin
        nsave++;
        if (save_at < 0) save_at = c;
      end
      if (o_rkwe != 0) nrkwe++;
    end
  endtask

  // ---------------- vector table for the ROUNDS=8/KEY_ROUNDS=4 instance
  typedef struct {
    bit v, md;
    int hold, save, rkwe, rkidx, ridx, krdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, bit md, int h, int s, int w,
                              int ki, int ri, int kr);
    vec_t t;
    t.v = v; t.md = md; t.hold = h; t.save = s; t.rkwe = w;
    t.rkidx = ki; t.ridx = ri; t.krdy = kr;
    tbl.push_back(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit v;
    // idle after reset, cold encrypt: rk_idx 0..3, rounds 0..7, save at 13
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) add(1, 0, 1, 0, 1, c - 1, 0, 0);
    for (int c = 5; c <= 12; c++) add(1, 0, 1, 0, 0, 0, c - 5, 1);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // warm decrypt: rounds 7..0, save at 9
    add(1, 1, 1, 0, 0, 0, 0, 1);
    for (int c = 1; c <= 8; c++) add(1, 1, 1, 0, 0, 0, 8 - c, 1);
    add(1, 1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);

    rest = 1'b1; valid_in = 1'b0; mode_dec = 1'b0; key_change = 1'b0;
    s_rest = 1'b1; s_valid = 1'b0; s_mode = 1'b0; s_kc = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    s_rest = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      s_valid = tbl[i].v; s_mode = tbl[i].md;
      #3;
      chkx($sformatf("tbl[%0d].hold", i), 32'(s_hold), tbl[i].hold);
      chkx($sformatf("tbl[%0d].save", i), 32'(s_save), tbl[i].save);
      chkx($sformatf("tbl[%0d].rk_we", i), 32'(s_rkwe), tbl[i].rkwe);
      chkx($sformatf("tbl[%0d].rk_idx", i), 32'(s_rkidx), tbl[i].rkidx);
      chkx($sformatf("tbl[%0d].round_idx", i), 32'(s_ridx), tbl[i].ridx);
      chkx($sformatf("tbl[%0d].key_ready", i), 32'(s_krdy), tbl[i].krdy);
    end

    // reset state of the large instance
    step(0, 0, 0, 0);
    chk("reset.key_ready", o_kr, 0);

    // cold encrypt
    run(67, 66, 0, -1, -1);
    chk("cold.save_at", save_at, 65);
    chk("cold.nsave", nsave, 1);
    chk("cold.nrkwe", nrkwe, 32);
    chk("cold.kr32", kr_a[32], 0);
    chk("cold.kr33", kr_a[33], 1);
    chk("cold.ridx64", ridx_a[64], 31);
    chk("cold.hold64", hold_a[64], 1);
    chk("cold.hold65", hold_a[65], 0);

    // warm decrypt
    run(35, 34, 1, -1, -1);
    chk("dec.save_at", save_at, 33);
    chk("dec.nrkwe", nrkwe, 0);
    chk("dec.ridx1", ridx_a[1], 31);
    chk("dec.ridx32", ridx_a[32], 0);
    chk("dec.hold33", hold_a[33], 0);

    // flush during round 10
    run(14, 11, 0, -1, -1);
    chk("abort.nsave", nsave, 0);
    chk("abort.hold", hold_a[11], 0);
    chk("abort.busy", busy_a[11], 0);
    run(36, 34, 0, -1, -1);
    chk("restart.ridx1", ridx_a[1], 0);
    chk("restart.save_at", save_at, 33);

    // flush inside key expansion
    step(0, 0, 0, 1);
    run(8, 5, 0, -1, -1);
    chk("kabort.nrkwe", nrkwe, 4);
    chk("kabort.kr", kr_a[7], 0);
    run(67, 66, 0, -1, -1);
    chk("kabort.reexp", nrkwe, 32);
    chk("kabort.save_at", save_at, 65);

    // key change during round 5, then a pulse on the last expansion cycle
    run(35, 34, 0, 6, -1);
    chk("kc.save_at", save_at, 33);
    chk("kc.kr_after", kr_a[34], 0);
    run(67, 66, 0, 32, -1);
    chk("kc.nrkwe", nrkwe, 32);
    chk("kc.kr_after2", kr_a[66], 0);

    // back-to-back with mode toggled inside the second block
    run(101, 100, 0, -1, 80);
    chk("b2b.nsave", nsave, 2);
    chk("b2b.save_at", save_at, 65);
    chk("b2b.hold66", hold_a[66], 1);
    chk("b2b.ridx90", ridx_a[90], 23);
    chk("b2b.hold99", hold_a[99], 0);

    // random traffic including flushes, key changes and mid-run reset
    v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (v) v = ($urandom_range(0, 59) != 0);
      else v = ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 399) == 0, v, 1'($urandom_range(0, 1)),
           $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
